// File: rtl/pcm1802_sample_packer_if.sv
// Word stream from the sample packer toward the USB transfer path.
// The master presents show-ahead words; the slave accepts them with word_ready.
interface pcm1802_sample_packer_if;
  logic [15:0] word_out;
  logic        word_valid;
  logic        word_ready;

  modport master (output word_out, output word_valid, input word_ready);
  modport slave  (input word_out, input word_valid, output word_ready);
endinterface

// File: rtl/pcm1802_sample_packer.sv
// Packs PCM1802 24-bit stereo pairs into 16-bit words behind a show-ahead FIFO.
// Optional header word with frame sequence number: define PCM_PACKER_FRAME_TAG_EN.
module pcm1802_sample_packer #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clk_40MHz,
  input  logic                    nReset,
  input  logic [23:0]             left_in,
  input  logic [23:0]             right_in,
  input  logic                    sample_ready_in,
  pcm1802_sample_packer_if.master word_if,
  output logic                    overflow,
  input  logic                    clear_overflow,
  output logic [15:0]             drop_count
);

`ifdef PCM_PACKER_FRAME_TAG_EN
  localparam int WPF = 4;
`else
  localparam int WPF = 3;
`endif
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] SPACE_LIMIT = (AW+1)'(FIFO_DEPTH - WPF);
  localparam logic [1:0]  LAST_IDX    = 2'(WPF - 1);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t          state, state_next;
  logic            s1, s2, s3;
  logic            frame_event, accept, drop;
  logic [23:0]     left_q, right_q;
  logic [1:0]      word_idx;
  logic            push, pop, word_valid_i;
  logic [15:0]     push_word;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [AW:0]     fifo_count;
  logic [15:0]     mem [FIFO_DEPTH];
`ifdef PCM_PACKER_FRAME_TAG_EN
  logic [7:0]      frame_seq, seq_q;
`endif

  // sample_ready_in is asynchronous; s3 gives the rising-edge detect.
  always_ff @(posedge clk_40MHz or negedge nReset) begin
    if (!nReset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sample_ready_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign frame_event = s2 & ~s3;
  assign accept      = frame_event && (state == IDLE) && (fifo_count <= SPACE_LIMIT);
  assign drop        = frame_event && !accept;

  always_ff @(posedge clk_40MHz or negedge nReset) begin
    if (!nReset) begin
      left_q  <= '0;
      right_q <= '0;
    end else if (accept) begin
      left_q  <= left_in;
      right_q <= right_in;
    end
  end

`ifdef PCM_PACKER_FRAME_TAG_EN
  // Sequence advances on every event, so dropped frames appear as gaps.
  always_ff @(posedge clk_40MHz or negedge nReset) begin
    if (!nReset) begin
      frame_seq <= '0;
      seq_q     <= '0;
    end else begin
      if (frame_event) frame_seq <= frame_seq + 8'd1;
      if (accept)      seq_q     <= frame_seq;
    end
  end
`endif

  always_ff @(posedge clk_40MHz or negedge nReset) begin
    if (!nReset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear_overflow) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

  always_ff @(posedge clk_40MHz or negedge nReset) begin
    if (!nReset) begin
      state    <= IDLE;
      word_idx <= '0;
    end else begin
      state <= state_next;
      if (state == WRITE && word_idx != LAST_IDX) word_idx <= word_idx + 2'd1;
      else                                        word_idx <= '0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = WRITE;
      WRITE:   if (word_idx == LAST_IDX) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    push      = (state == WRITE);
    push_word = 16'h0000;
`ifdef PCM_PACKER_FRAME_TAG_EN
    case (word_idx)
      2'd0:    push_word = {8'hA5, seq_q};
      2'd1:    push_word = left_q[23:8];
      2'd2:    push_word = {left_q[7:0], right_q[23:16]};
      default: push_word = right_q[15:0];
    endcase
`else
    case (word_idx)
      2'd0:    push_word = left_q[23:8];
      2'd1:    push_word = {left_q[7:0], right_q[23:16]};
      default: push_word = right_q[15:0];
    endcase
`endif
  end

  assign word_valid_i       = (fifo_count != '0);
  assign pop                = word_valid_i & word_if.word_ready;
  assign word_if.word_valid = word_valid_i;
  assign word_if.word_out   = word_valid_i ? mem[rd_ptr] : 16'h0000;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_40MHz) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk_40MHz or negedge nReset) begin
    if (!nReset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule
